// File: rtl/alu_cmd_sequencer.sv
// Command-side sequencer for the 8-bit combinational ALU: valid/ready command in, registered ALU drive,
// programmable settle wait, then a held valid/ready response. Optional accumulator via `ALU_SEQ_ACC_EN.
module alu_cmd_sequencer #(
    parameter int SETTLE_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [1:0]       cmd_shamt,
`ifdef ALU_SEQ_ACC_EN
    input  logic             cmd_acc,
`endif
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [1:0]       alu_shiftdesp,
    output logic [2:0]       alu_ctrl,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [1:0]       alu_sh_q, alu_sh_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] ops_count_q, ops_count_d;
`ifdef ALU_SEQ_ACC_EN
    logic [7:0]       acc_q, acc_d;
`endif

    logic accept;
    logic capture;
    logic rsp_done;

    assign accept   = cmd_valid && (state_q == IDLE);
    assign capture  = (state_q == EXEC) && (wait_q == 4'd0);
    assign rsp_done = (state_q == RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = EXEC;
            EXEC:    if (capture)  state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
    end

    // Datapath registers: operands load on accept and then hold, even after the response leaves.
    always_comb begin
        wait_d       = wait_q;
        illegal_d    = illegal_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sh_d     = alu_sh_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        ops_count_d  = ops_count_q;
`ifdef ALU_SEQ_ACC_EN
        acc_d        = acc_q;
`endif

        if (accept) begin
`ifdef ALU_SEQ_ACC_EN
            alu_a_d = cmd_acc ? acc_q : cmd_a;
`else
            alu_a_d = cmd_a;
`endif
            alu_b_d    = cmd_b;
            alu_sh_d   = cmd_shamt;
            alu_ctrl_d = cmd_op;
            illegal_d  = cmd_op[2] & cmd_op[1];
            wait_d     = SETTLE_INIT;
        end

        if ((state_q == EXEC) && (wait_q != 4'd0)) begin
            wait_d = wait_q - 4'd1;
        end

        if (capture) begin
            if (illegal_q) begin
                rsp_result_d = 8'h00;
                rsp_flags_d  = 4'b0000;
                rsp_err_d    = 1'b1;
            end else begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {alu_negative, alu_zero, alu_carry, alu_overflow};
                rsp_err_d    = 1'b0;
`ifdef ALU_SEQ_ACC_EN
                acc_d        = alu_result;
`endif
            end
        end

        if (rsp_done) begin
            ops_count_d = ops_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q       <= 4'd0;
            illegal_q    <= 1'b0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_sh_q     <= 2'd0;
            alu_ctrl_q   <= 3'd0;
            rsp_result_q <= 8'h00;
            rsp_flags_q  <= 4'b0000;
            rsp_err_q    <= 1'b0;
            ops_count_q  <= '0;
`ifdef ALU_SEQ_ACC_EN
            acc_q        <= 8'h00;
`endif
        end else begin
            wait_q       <= wait_d;
            illegal_q    <= illegal_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sh_q     <= alu_sh_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            ops_count_q  <= ops_count_d;
`ifdef ALU_SEQ_ACC_EN
            acc_q        <= acc_d;
`endif
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_shiftdesp = alu_sh_q;
    assign alu_ctrl      = alu_ctrl_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_flags     = rsp_flags_q;
    assign rsp_err       = rsp_err_q;
    assign ops_count     = ops_count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 0 / settle 3, the latter with a 3-bit counter)
// each driving a behavioural ALU; a scoreboard queue holds expected responses.
module tb_alu_cmd_sequencer;

    localparam int SETTLE0 = 0;
    localparam int SETTLE1 = 3;

    typedef struct {
        logic [7:0] result;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sel = 0;

    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_a = 8'h00;
    logic [7:0] cmd_b = 8'h00;
    logic [1:0] cmd_shamt = 2'd0;
    logic       cmd_acc = 1'b0;
    logic       rsp_ready = 1'b0;

    logic       cmd_ready_w [2];
    logic [7:0] alu_a_w [2];
    logic [7:0] alu_b_w [2];
    logic [1:0] alu_sh_w [2];
    logic [2:0] alu_ctrl_w [2];
    logic       rsp_valid_w [2];
    logic [7:0] rsp_result_w [2];
    logic [3:0] rsp_flags_w [2];
    logic       rsp_err_w [2];
    logic [7:0] ops0;
    logic [2:0] ops1;
    logic [11:0] alu0, alu1;

    logic       cmd_ready_m, rsp_valid_m, rsp_err_m;
    logic [7:0] alu_a_m, alu_b_m, rsp_result_m, ops_m;
    logic [1:0] alu_sh_m;
    logic [2:0] alu_ctrl_m;
    logic [3:0] rsp_flags_m;

    exp_t       sbq[$];
    logic [7:0] cnt_model [2];
    logic [7:0] acc_model [2];
    logic [7:0] cnt_mask  [2];
    int         settle    [2];

    // Behavioural ALU returning {N,Z,C,V,result}; illegal opcodes produce junk so gating is visible.
    function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic [1:0] sh);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0]; c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            3'd1: begin
                r = a - b; c = (a >= b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin
                r = a << sh;
                if (sh != 2'd0) c = a[8 - int'(sh)];
            end
            3'd5: begin
                r = a >> sh;
                if (sh != 2'd0) c = a[int'(sh) - 1];
            end
            default: begin
                r = a ^ b; c = 1'b1; v = 1'b1;
            end
        endcase
        return {r[7], (r == 8'd0), c, v, r};
    endfunction

    always_comb begin
        alu0 = alu_fn(alu_ctrl_w[0], alu_a_w[0], alu_b_w[0], alu_sh_w[0]);
        alu1 = alu_fn(alu_ctrl_w[1], alu_a_w[1], alu_b_w[1], alu_sh_w[1]);
    end

    alu_cmd_sequencer #(.SETTLE_CYCLES(SETTLE0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid && (sel == 0)), .cmd_ready(cmd_ready_w[0]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
`ifdef ALU_SEQ_ACC_EN
        .cmd_acc(cmd_acc),
`endif
        .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_shiftdesp(alu_sh_w[0]), .alu_ctrl(alu_ctrl_w[0]),
        .alu_result(alu0[7:0]), .alu_zero(alu0[10]), .alu_negative(alu0[11]),
        .alu_carry(alu0[9]), .alu_overflow(alu0[8]),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready && (sel == 0)),
        .rsp_result(rsp_result_w[0]), .rsp_flags(rsp_flags_w[0]), .rsp_err(rsp_err_w[0]),
        .ops_count(ops0)
    );

    alu_cmd_sequencer #(.SETTLE_CYCLES(SETTLE1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid && (sel == 1)), .cmd_ready(cmd_ready_w[1]),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt),
`ifdef ALU_SEQ_ACC_EN
        .cmd_acc(cmd_acc),
`endif
        .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_shiftdesp(alu_sh_w[1]), .alu_ctrl(alu_ctrl_w[1]),
        .alu_result(alu1[7:0]), .alu_zero(alu1[10]), .alu_negative(alu1[11]),
        .alu_carry(alu1[9]), .alu_overflow(alu1[8]),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready && (sel == 1)),
        .rsp_result(rsp_result_w[1]), .rsp_flags(rsp_flags_w[1]), .rsp_err(rsp_err_w[1]),
        .ops_count(ops1)
    );

    always_comb begin
        cmd_ready_m  = (sel == 1) ? cmd_ready_w[1]  : cmd_ready_w[0];
        rsp_valid_m  = (sel == 1) ? rsp_valid_w[1]  : rsp_valid_w[0];
        rsp_err_m    = (sel == 1) ? rsp_err_w[1]    : rsp_err_w[0];
        alu_a_m      = (sel == 1) ? alu_a_w[1]      : alu_a_w[0];
        alu_b_m      = (sel == 1) ? alu_b_w[1]      : alu_b_w[0];
        alu_sh_m     = (sel == 1) ? alu_sh_w[1]     : alu_sh_w[0];
        alu_ctrl_m   = (sel == 1) ? alu_ctrl_w[1]   : alu_ctrl_w[0];
        rsp_result_m = (sel == 1) ? rsp_result_w[1] : rsp_result_w[0];
        rsp_flags_m  = (sel == 1) ? rsp_flags_w[1]  : rsp_flags_w[0];
        ops_m        = (sel == 1) ? {5'd0, ops1}    : ops0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s (dut%0d): got 0x%0h expected 0x%0h", tag, sel, got, exp);
        end
    endtask

    task automatic checkIdleReset();
        checkOutput("rst_alu_a", alu_a_m, 0);
        checkOutput("rst_alu_b", alu_b_m, 0);
        checkOutput("rst_alu_sh", alu_sh_m, 0);
        checkOutput("rst_alu_ctrl", alu_ctrl_m, 0);
        checkOutput("rst_rsp_valid", rsp_valid_m, 0);
        checkOutput("rst_rsp_result", rsp_result_m, 0);
        checkOutput("rst_rsp_flags", rsp_flags_m, 0);
        checkOutput("rst_rsp_err", rsp_err_m, 0);
        checkOutput("rst_ops_count", ops_m, 0);
    endtask

    // Issue one command on the selected instance, push its expectation, then collect and retire it.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] sh, input logic acc, input int hold);
        int         guard;
        int         lat;
        logic [7:0] a_eff;
        logic [7:0] held;
        logic [11:0] r;
        exp_t       e;
        a_eff = a;
`ifdef ALU_SEQ_ACC_EN
        if (acc) a_eff = acc_model[sel];
`endif
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_acc = acc;
        cmd_valid = 1'b1;
        guard = 0;
        while (!cmd_ready_m && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        r = alu_fn(op, a_eff, b, sh);
        e.err    = op[2] & op[1];
        e.result = e.err ? 8'h00 : r[7:0];
        e.flags  = e.err ? 4'h0 : r[11:8];
        sbq.push_back(e);

        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("alu_a", alu_a_m, a_eff);
        checkOutput("alu_b", alu_b_m, b);
        checkOutput("alu_shiftdesp", alu_sh_m, sh);
        checkOutput("alu_ctrl", alu_ctrl_m, op);
        checkOutput("exec_cmd_ready", cmd_ready_m, 0);

        lat = 0;
        while (!rsp_valid_m && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput("latency", lat, 1 + settle[sel]);
        if (!rsp_valid_m) begin
            e = sbq.pop_front();
            return;
        end

        held = rsp_result_m;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_rsp_valid", rsp_valid_m, 1);
            checkOutput("hold_rsp_result", rsp_result_m, held);
            checkOutput("hold_cmd_ready", cmd_ready_m, 0);
        end

        e = sbq.pop_front();
        checkOutput("rsp_result", rsp_result_m, e.result);
        checkOutput("rsp_flags", rsp_flags_m, e.flags);
        checkOutput("rsp_err", rsp_err_m, e.err);

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cnt_model[sel] = (cnt_model[sel] + 8'd1) & cnt_mask[sel];
        if (!e.err) acc_model[sel] = e.result;
        checkOutput("rsp_valid_drop", rsp_valid_m, 0);
        checkOutput("ops_count", ops_m, cnt_model[sel]);
        checkOutput("idle_cmd_ready", cmd_ready_m, 1);
        checkOutput("alu_a_kept", alu_a_m, a_eff);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cnt_mask  = '{8'hFF, 8'h07};
        settle    = '{SETTLE0, SETTLE1};
        cnt_model = '{8'h00, 8'h00};
        acc_model = '{8'h00, 8'h00};

        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            checkIdleReset();
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_cmd_ready", cmd_ready_m, 1);
        checkOutput("post_reset_rsp_valid", rsp_valid_m, 0);

        sel = 0;
        applyStimulus(3'd0, 8'hFF, 8'h01, 2'd0, 1'b0, 0);
        applyStimulus(3'd0, 8'h7F, 8'h01, 2'd0, 1'b0, 5);
        applyStimulus(3'd1, 8'h10, 8'h20, 2'd0, 1'b0, 1);
        applyStimulus(3'd2, 8'hF0, 8'h3C, 2'd0, 1'b0, 0);
        applyStimulus(3'd3, 8'h0F, 8'h30, 2'd0, 1'b0, 0);
        applyStimulus(3'd4, 8'hC1, 8'h00, 2'd2, 1'b0, 0);
        applyStimulus(3'd5, 8'h85, 8'h00, 2'd3, 1'b0, 2);
        applyStimulus(3'd6, 8'h5A, 8'hA5, 2'd1, 1'b0, 1);
        applyStimulus(3'd7, 8'h12, 8'h34, 2'd0, 1'b0, 0);

        sel = 1;
        @(negedge clk);
        applyStimulus(3'd4, 8'h81, 8'h00, 2'd1, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                          2'($urandom_range(0, 3)), 1'b0, $urandom_range(0, 2));
        end

`ifdef ALU_SEQ_ACC_EN
        sel = 0;
        @(negedge clk);
        applyStimulus(3'd0, 8'h10, 8'h05, 2'd0, 1'b0, 0);
        applyStimulus(3'd0, 8'hEE, 8'h01, 2'd0, 1'b1, 0);
        checkOutput("acc_chain_result", rsp_result_m, 8'h16);
        applyStimulus(3'd6, 8'h11, 8'h22, 2'd0, 1'b0, 0);
        applyStimulus(3'd1, 8'h00, 8'h06, 2'd0, 1'b1, 0);
        checkOutput("acc_after_illegal", rsp_result_m, 8'h10);
`endif

        // Abort an operation mid-EXEC on the settle-3 instance.
        sel = 1;
        @(negedge clk);
        cmd_op = 3'd0; cmd_a = 8'h01; cmd_b = 8'h02; cmd_shamt = 2'd0; cmd_acc = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("abort_in_exec", cmd_ready_m, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkIdleReset();
        @(negedge clk);
        rst_n = 1'b1;
        cnt_model = '{8'h00, 8'h00};
        acc_model = '{8'h00, 8'h00};
        sbq.delete();
        @(negedge clk);
        checkOutput("abort_cmd_ready", cmd_ready_m, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", rsp_valid_m, 0);
        end
        checkOutput("abort_ops_count", ops_m, 0);
        applyStimulus(3'd0, 8'h20, 8'h22, 2'd0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
